// File: rtl/calc_mdu_ctrl.sv
// ---------------------------------------------------------------------------
// calc_mdu_ctrl
//
// Sequencing controller for the shared iterative multiply/divide unit of the
// calculator. A one-cycle start request latches two WIDTH-bit operands and an
// op select. The unit then runs a shift-add multiply or a restoring divide,
// one iteration per cycle for WIDTH cycles. The result is returned in
// registers that hold their value until the next accepted start.
//
// Ports
//   clk          system clock, all state on the rising edge
//   reset        asynchronous, active-low reset
//   clear        synchronous abort/clear, active-high (priority over start)
//   start        request pulse, sampled only in IDLE or DONE
//   op           0 = multiply, 1 = divide (sampled with start)
//   a            multiplicand / dividend (sampled with start)
//   b            multiplier / divisor (sampled with start)
//   busy         high while iterating (RUN)
//   done         one-cycle completion pulse (DONE)
//   result       2*WIDTH-bit product, or zero-extended quotient
//   remainder    division remainder, 0 after a multiply
//   div_by_zero  set when a divide with b == 0 completes
// ---------------------------------------------------------------------------
module calc_mdu_ctrl #(
    parameter int WIDTH = 6,
    parameter int CW    = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 start,
    input  logic                 op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic [WIDTH-1:0]     remainder,
    output logic                 div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    state_t               state_reg;
    logic [CW-1:0]        cnt_reg;
    logic                 op_reg;
    logic [WIDTH-1:0]     a_reg;
    logic [WIDTH-1:0]     b_reg;
    logic [2*WIDTH-1:0]   p_reg;      // multiply: {partial high, remaining multiplier}
    logic [WIDTH:0]       rem_reg;    // divide: partial remainder R
    logic [WIDTH-1:0]     q_reg;      // divide: dividend shifting into quotient

    logic                 busy_reg;
    logic                 done_reg;
    logic [2*WIDTH-1:0]   result_reg;
    logic [WIDTH-1:0]     remainder_reg;
    logic                 dbz_reg;

    // -----------------------------------------------------------------------
    // One iteration of each algorithm, computed from the current registers.
    // -----------------------------------------------------------------------
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   p_next;
    logic [WIDTH+1:0]     r_shift;
    logic [WIDTH+1:0]     trial;
    logic [WIDTH:0]       r_next;
    logic [WIDTH-1:0]     q_next;

    always_comb begin
        // Shift-add: conditional add into the upper half with carry, then
        // shift {carry, P} right by one.
        mul_sum = {1'b0, p_reg[2*WIDTH-1:WIDTH]} + (p_reg[0] ? {1'b0, a_reg} : '0);
        p_next  = {mul_sum, p_reg[WIDTH-1:1]};

        // Restoring divide: shift {R, Q} left, then trial-subtract B.
        // One spare bit on the trial so its sign is unambiguous.
        r_shift = {rem_reg, q_reg[WIDTH-1]};
        trial   = r_shift - {2'b00, b_reg};
        if (!trial[WIDTH+1]) begin
            r_next = trial[WIDTH:0];
            q_next = {q_reg[WIDTH-2:0], 1'b1};
        end else begin
            r_next = r_shift[WIDTH:0];
            q_next = {q_reg[WIDTH-2:0], 1'b0};
        end
    end

    // -----------------------------------------------------------------------
    // Controller FSM with registered outputs.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            op_reg        <= 1'b0;
            a_reg         <= '0;
            b_reg         <= '0;
            p_reg         <= '0;
            rem_reg       <= '0;
            q_reg         <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            result_reg    <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
        end else if (clear) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            op_reg        <= 1'b0;
            a_reg         <= '0;
            b_reg         <= '0;
            p_reg         <= '0;
            rem_reg       <= '0;
            q_reg         <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            result_reg    <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start && op && (b == '0)) begin
                        // Divide by zero completes immediately with a
                        // saturated quotient and the dividend as remainder.
                        state_reg     <= DONE;
                        busy_reg      <= 1'b0;
                        done_reg      <= 1'b1;
                        result_reg    <= '1;
                        remainder_reg <= a;
                        dbz_reg       <= 1'b1;
                    end else if (start) begin
                        state_reg     <= RUN;
                        cnt_reg       <= '0;
                        op_reg        <= op;
                        a_reg         <= a;
                        b_reg         <= b;
                        p_reg         <= {{WIDTH{1'b0}}, b};
                        rem_reg       <= '0;
                        q_reg         <= a;
                        busy_reg      <= 1'b1;
                        done_reg      <= 1'b0;
                        result_reg    <= '0;
                        remainder_reg <= '0;
                        dbz_reg       <= 1'b0;
                    end else begin
                        state_reg     <= IDLE;
                        busy_reg      <= 1'b0;
                        done_reg      <= 1'b0;
                    end
                end

                RUN: begin
                    cnt_reg <= cnt_reg + CW'(1);
                    if (op_reg) begin
                        rem_reg <= r_next;
                        q_reg   <= q_next;
                    end else begin
                        p_reg   <= p_next;
                    end
                    if (cnt_reg == LAST_ITER) begin
                        // Final iteration lands straight in the output registers.
                        state_reg     <= DONE;
                        busy_reg      <= 1'b0;
                        done_reg      <= 1'b1;
                        dbz_reg       <= 1'b0;
                        if (op_reg) begin
                            result_reg    <= {{WIDTH{1'b0}}, q_next};
                            remainder_reg <= r_next[WIDTH-1:0];
                        end else begin
                            result_reg    <= p_next;
                            remainder_reg <= '0;
                        end
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_reg;
    assign done        = done_reg;
    assign result      = result_reg;
    assign remainder   = remainder_reg;
    assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_calc_mdu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_calc_mdu_ctrl
//
// Directed and random operations on calc_mdu_ctrl with WIDTH=6. Expected
// values come from plain integer arithmetic (a*b, a/b, a%b). Inputs are
// driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_calc_mdu_ctrl;

    localparam int WIDTH = 6;
    localparam int LAT   = WIDTH + 1;

    logic                 clk;
    logic                 reset;
    logic                 clear;
    logic                 start;
    logic                 op;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   result;
    logic [WIDTH-1:0]     remainder;
    logic                 div_by_zero;

    int vectors = 0;
    int miscompares = 0;

    calc_mdu_ctrl #(.WIDTH(WIDTH), .CW(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, ".busy"}, {31'd0, busy}, 32'd0);
        check({tag, ".done"}, {31'd0, done}, 32'd0);
        check({tag, ".result"}, {20'd0, result}, 32'd0);
        check({tag, ".rem"}, {26'd0, remainder}, 32'd0);
        check({tag, ".dbz"}, {31'd0, div_by_zero}, 32'd0);
    endtask

    // Drive a one-cycle start; returns at the falling edge after the sampling
    // edge. Operands are scrambled afterwards to show they are not re-read.
    task automatic pulse_start(input logic o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        op = 1'($urandom);
    endtask

    // Wait (bounded) for done; counts edges since the sampling edge and the
    // number of sampled cycles with busy high.
    task automatic wait_done(input int already, output int edges, output int busy_cycles);
        edges = already;
        busy_cycles = 0;
        while (!done && edges < 40) begin
            if (busy) busy_cycles++;
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic check_result(input string tag, input logic o, input int x, input int y);
        int exp_res, exp_rem, exp_dbz;
        if (o && y == 0) begin
            exp_res = (1 << (2*WIDTH)) - 1; exp_rem = x; exp_dbz = 1;
        end else if (o) begin
            exp_res = x / y; exp_rem = x % y; exp_dbz = 0;
        end else begin
            exp_res = x * y; exp_rem = 0; exp_dbz = 0;
        end
        check({tag, ".result"}, {20'd0, result}, 32'(exp_res));
        check({tag, ".rem"}, {26'd0, remainder}, 32'(exp_rem));
        check({tag, ".dbz"}, {31'd0, div_by_zero}, 32'(exp_dbz));
    endtask

    // Complete operation: start, latency, busy length, results, single-cycle
    // done and output hold afterwards.
    task automatic do_op(input string tag, input logic o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        int edges, bcyc;
        bit dz;
        dz = o && (y == '0);
        pulse_start(o, x, y);
        wait_done(1, edges, bcyc);
        check({tag, ".latency"}, 32'(edges), dz ? 32'd1 : 32'(LAT));
        check({tag, ".busy_cycles"}, 32'(bcyc), dz ? 32'd0 : 32'(WIDTH));
        check({tag, ".done"}, {31'd0, done}, 32'd1);
        check({tag, ".busy_in_done"}, {31'd0, busy}, 32'd0);
        check_result(tag, o, int'(x), int'(y));
        @(negedge clk);
        check({tag, ".done_pulse"}, {31'd0, done}, 32'd0);
        check_result({tag, ".hold"}, o, int'(x), int'(y));
        $display("op=%s a=%0d b=%0d -> result=%0d rem=%0d dbz=%0d latency=%0d",
                 o ? "div" : "mul", x, y, result, remainder, div_by_zero, edges);
    endtask

    initial begin
        int edges, bcyc, cnt;
        logic o;
        logic [WIDTH-1:0] x, y;

        reset = 1'b0; clear = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        reset = 1'b1;
        @(negedge clk);
        check_zero_outputs("after_reset");

        // Directed test plan
        do_op("mul63x63", 1'b0, 6'd63, 6'd63);
        do_op("div45/7", 1'b1, 6'd45, 6'd7);
        do_op("div5/9", 1'b1, 6'd5, 6'd9);
        do_op("div20/0", 1'b1, 6'd20, 6'd0);
        do_op("mul2x3", 1'b0, 6'd2, 6'd3);
        do_op("div63/1", 1'b1, 6'd63, 6'd1);
        do_op("mul0x63", 1'b0, 6'd0, 6'd63);

        // Start during RUN is ignored; start in DONE is accepted.
        pulse_start(1'b0, 6'd3, 6'd4);
        repeat (2) @(negedge clk);
        start = 1'b1; op = 1'b0; a = 6'd5; b = 6'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done(4, edges, bcyc);
        check("busy_start.latency", 32'(edges), 32'(LAT));
        check("busy_start.done", {31'd0, done}, 32'd1);
        check_result("busy_start", 1'b0, 3, 4);
        start = 1'b1; op = 1'b0; a = 6'd5; b = 6'd5;
        @(negedge clk);
        start = 1'b0;
        check("b2b.busy", {31'd0, busy}, 32'd1);
        check("b2b.cleared", {20'd0, result}, 32'd0);
        wait_done(1, edges, bcyc);
        check("b2b.latency", 32'(edges), 32'(LAT));
        check_result("b2b", 1'b0, 5, 5);
        $display("back-to-back 3x4 then 5x5 -> result=%0d latency=%0d", result, edges);

        // Clear mid-run: no done pulse, outputs zero.
        pulse_start(1'b1, 6'd10, 6'd3);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check_zero_outputs("clear_run");
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (done || busy) cnt++;
        end
        check("clear_run.no_done", 32'(cnt), 32'd0);
        $display("clear mid-run -> busy=%0d done=%0d result=%0d", busy, done, result);

        // Clear zeroes held outputs; clear beats start in the same cycle.
        do_op("mul5x5", 1'b0, 6'd5, 6'd5);
        @(negedge clk);
        clear = 1'b1; start = 1'b1; op = 1'b0; a = 6'd2; b = 6'd3;
        @(negedge clk);
        clear = 1'b0; start = 1'b0;
        check_zero_outputs("clear_start");
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (done || busy) cnt++;
        end
        check("clear_start.idle", 32'(cnt), 32'd0);
        $display("clear+start same cycle -> busy=%0d result=%0d", busy, result);

        // Asynchronous reset between edges during RUN.
        pulse_start(1'b0, 6'd9, 6'd9);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 check_zero_outputs("async_reset");
        @(negedge clk);
        reset = 1'b1;
        $display("async reset mid-run -> busy=%0d result=%0d", busy, result);
        do_op("mul7x9", 1'b0, 6'd7, 6'd9);

        // Random operations, including occasional zero divisors.
        for (int i = 0; i < 40; i++) begin
            o = 1'($urandom);
            x = WIDTH'($urandom);
            y = ($urandom_range(0, 7) == 0) ? '0 : WIDTH'($urandom);
            do_op($sformatf("rnd%0d", i), o, x, y);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/calc_mdu_ctrl.md
Name: calc_mdu_ctrl

Overview:
Sequencing controller for a shared multi-cycle multiply/divide unit used by the calculator datapath.
- Accepts a one-cycle start request with operands and an op select.
- Runs an iterative shift-add multiply or restoring divide over WIDTH cycles.
- Returns a registered result with a done pulse.
- Sits between calc_fsm and calc_datapath: calc_fsm issues start/clear, and the datapath consumes result/done.

Parameters:
WIDTH, 6, operand width in bits (matches the switch operand width)
CW, 3, iteration counter width; must satisfy 2^CW > WIDTH

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
clear  input  1  synchronous abort/clear from calc_fsm, active-high
start  input  1  request pulse; sampled only in IDLE or DONE
op  input  1  0 = multiply, 1 = divide; sampled with start
a  input  WIDTH  operand A (multiplicand / dividend); sampled with start
b  input  WIDTH  operand B (multiplier / divisor); sampled with start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse, high only in DONE
result  output  2*WIDTH  product, or zero-extended quotient
remainder  output  WIDTH  division remainder; 0 after multiply
div_by_zero  output  1  set when a divide with b==0 completes

Behaviour:
- reset low (asynchronous): state=IDLE, counter=0, all internal registers 0, busy=0, done=0, result=0, remainder=0, div_by_zero=0. Takes effect mid-operation with no completion pulse.
- States: IDLE, RUN, DONE; binary encoded; no unreachable states, default branch to IDLE.
- IDLE:
  - start=1, no divide-by-zero: latch a, b, op; counter=0; go to RUN.
  - start=1, op=1, b==0: go directly to DONE. Next-cycle outputs: result = all ones (quotient saturates), remainder=a, div_by_zero=1.
- RUN: busy=1, one iteration per cycle, counter increments. When counter==WIDTH-1, that iteration executes and the state goes to DONE.
- Multiply:
  - Product register P[2W-1:0] initialised to {0, b}.
  - Each cycle: if P[0], add A to P[2W-1:W] with carry into a (W+1)-bit sum; then shift {carry, P} right by 1.
  - Result is exact with no overflow (2W bits).
- Divide (restoring):
  - Remainder register R (W+1 bits) = 0; Q = a.
  - Each cycle: shift {R, Q} left 1; trial = R - B; if trial is non-negative, R = trial and Q[0] = 1, else Q[0] = 0.
  - At end: result = {0, Q}, remainder = R[W-1:0].
- DONE: lasts exactly 1 cycle.
  - done=1, busy=0; result/remainder/div_by_zero valid.
  - start=1 in DONE is accepted exactly as in IDLE (back-to-back operation); otherwise go to IDLE.
- Latency: done is high in the cycle after WIDTH+1 rising edges following the edge that samples start (WIDTH=6: 7 edges). Divide-by-zero: 1 edge.
- Output hold: result/remainder/div_by_zero are registered and hold their values through IDLE until the next accepted start. They are cleared to 0 on accepting a new start, with div_by_zero cleared at the same edge.
- start during RUN is ignored, with no queuing. Operand changes during RUN have no effect.
- clear=1: at the next edge go to IDLE, zero the counter and all outputs, no done pulse. clear has priority over start in the same cycle.
- Simultaneous reset and clear: reset wins (asynchronous).

Test Plan:
- Multiply, WIDTH=6: a=63, b=63, op=0, 1-cycle start -> busy high 6 cycles, done pulse at edge 7, result=3969, remainder=0, div_by_zero=0.
- Divide: a=45, b=7, op=1 -> done at edge 7, result=6, remainder=3. Second case a=5, b=9 -> result=0, remainder=5.
- Divide-by-zero: a=20, b=0, op=1 -> done one edge after start, busy never high, result=12'hFFF, remainder=20, div_by_zero=1. A following multiply 2*3 -> div_by_zero=0, result=6.
- Start while busy, then back-to-back: start 3*4; pulse start with 5*5 at RUN cycle 3 -> ignored, result=12. Start asserted in the DONE cycle with 5*5 -> accepted, next done gives 25.
- Clear mid-run: start 10/3; assert clear at RUN cycle 2 -> IDLE next edge, no done, outputs 0. Clear and start in the same cycle -> stays IDLE.
- Async reset mid-run: drop reset between edges during RUN -> all outputs 0 immediately. Release, then start 7*9 -> result=63 at edge 7.
